// File: rtl/bridge_arbiter_if.sv
// Signal bundle between the two requesters, the bridge arbiter and the bridge.
// The arbiter uses the slave modport; the requesters and bridge side use master.
interface bridge_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
);
  logic              req0_valid;
  logic              req0_r_wb;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data_w;
  logic              req0_ready;
  logic              rsp0_valid;

  logic              req1_valid;
  logic              req1_r_wb;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data_w;
  logic              req1_ready;
  logic              rsp1_valid;

  logic [DATA_W-1:0] rsp_data_r;
  logic              rsp_err;

  logic              C_in_valid;
  logic              C_r_wb;
  logic [ADDR_W-1:0] C_addr;
  logic [DATA_W-1:0] C_data_w;
  logic              C_out_valid;
  logic [DATA_W-1:0] C_data_r;

  logic              busy;

  modport slave (
    input  req0_valid, req0_r_wb, req0_addr, req0_data_w,
    input  req1_valid, req1_r_wb, req1_addr, req1_data_w,
    input  C_out_valid, C_data_r,
    output req0_ready, rsp0_valid, req1_ready, rsp1_valid,
    output rsp_data_r, rsp_err,
    output C_in_valid, C_r_wb, C_addr, C_data_w,
    output busy
  );

  modport master (
    output req0_valid, req0_r_wb, req0_addr, req0_data_w,
    output req1_valid, req1_r_wb, req1_addr, req1_data_w,
    output C_out_valid, C_data_r,
    input  req0_ready, rsp0_valid, req1_ready, rsp1_valid,
    input  rsp_data_r, rsp_err,
    input  C_in_valid, C_r_wb, C_addr, C_data_w,
    input  busy
  );
endinterface

// File: rtl/bridge_arbiter.sv
// Round-robin arbiter sharing one bridge port between two requesters.
// One transaction in flight at a time, with a response watchdog in WAIT.
module bridge_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 64,
  parameter int TMO_CYC = 1023
) (
  input  logic          clk,
  input  logic          rst_n,
  bridge_arbiter_if.slave bus
);

  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic              r_owner;
  logic              r_rr_last;
  logic              r_rwb;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data_w;
  logic [TW-1:0]     r_timer;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic              w_any;
  logic              w_grant;
  logic              w_timeout;
  logic              w_ready0;
  logic              w_ready1;
  logic              w_cin;
  logic              w_rsp0;
  logic              w_rsp1;

  assign w_any     = bus.req0_valid | bus.req1_valid;
  // On a tie the port that did not win last time is served.
  assign w_grant   = (bus.req0_valid & bus.req1_valid) ? ~r_rr_last : bus.req1_valid;
  assign w_timeout = (r_timer == TMO_LAST);

  always_comb begin
    w_next   = r_state;
    w_ready0 = 1'b0;
    w_ready1 = 1'b0;
    w_cin    = 1'b0;
    w_rsp0   = 1'b0;
    w_rsp1   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_ready0 = ~w_grant;
          w_ready1 = w_grant;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cin  = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (bus.C_out_valid || w_timeout) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        w_rsp0 = ~r_owner;
        w_rsp1 = r_owner;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner   <= 1'b0;
      r_rr_last <= 1'b1;
      r_rwb     <= 1'b0;
      r_addr    <= '0;
      r_data_w  <= '0;
      r_timer   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner   <= w_grant;
            r_rr_last <= w_grant;
            r_rwb     <= w_grant ? bus.req1_r_wb   : bus.req0_r_wb;
            r_addr    <= w_grant ? bus.req1_addr   : bus.req0_addr;
            r_data_w  <= w_grant ? bus.req1_data_w : bus.req0_data_w;
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
        end
        S_WAIT: begin
          // Completion takes priority over a coincident timeout.
          if (bus.C_out_valid) begin
            r_rdata <= bus.C_data_r;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.rsp0_valid = w_rsp0;
  assign bus.rsp1_valid = w_rsp1;
  assign bus.rsp_data_r = r_rdata;
  assign bus.rsp_err    = r_err;
  assign bus.C_in_valid = w_cin;
  assign bus.C_r_wb     = r_rwb;
  assign bus.C_addr     = r_addr;
  assign bus.C_data_w   = r_data_w;
  assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_bridge_arbiter.sv
// Directed bench for bridge_arbiter: bridge model with programmable latency,
// event log of ready/issue/response cycles, and hand-computed expectations.
module tb_bridge_arbiter;

  localparam int AW  = 8;
  localparam int DW  = 64;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bridge_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bridge_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // event log
  int          rdy_port[$];
  int          rdy_cyc[$];
  int          rsp_port[$];
  int          rsp_cyc[$];
  logic [63:0] rsp_data[$];
  logic        rsp_errq[$];
  int          cin_cyc = -1;
  logic        cin_rwb;
  logic [7:0]  cin_addr;
  logic [63:0] cin_dw;

  always @(negedge clk) begin
    if (bus.req0_ready === 1'b1) begin rdy_port.push_back(0); rdy_cyc.push_back(cyc); end
    if (bus.req1_ready === 1'b1) begin rdy_port.push_back(1); rdy_cyc.push_back(cyc); end
    if (bus.C_in_valid === 1'b1) begin
      cin_cyc  = cyc;
      cin_rwb  = bus.C_r_wb;
      cin_addr = bus.C_addr;
      cin_dw   = bus.C_data_w;
    end
    if (bus.rsp0_valid === 1'b1) begin
      rsp_port.push_back(0); rsp_cyc.push_back(cyc);
      rsp_data.push_back(bus.rsp_data_r); rsp_errq.push_back(bus.rsp_err);
    end
    if (bus.rsp1_valid === 1'b1) begin
      rsp_port.push_back(1); rsp_cyc.push_back(cyc);
      rsp_data.push_back(bus.rsp_data_r); rsp_errq.push_back(bus.rsp_err);
    end
  end

  // bridge model: answers L cycles after the issue cycle
  int          br_lat  = 3;
  logic [63:0] br_data = '0;
  int          br_done = 0;

  initial begin
    bus.C_out_valid = 1'b0;
    bus.C_data_r    = '0;
    forever begin
      @(negedge clk);
      if (bus.C_in_valid === 1'b1) begin
        repeat (br_lat) @(posedge clk);
        #1;
        bus.C_out_valid = 1'b1;
        bus.C_data_r    = br_data;
        @(posedge clk);
        #1;
        bus.C_out_valid = 1'b0;
        br_done++;
      end
    end
  end

  task automatic send(input int p, input logic rwb, input logic [7:0] a, input logic [63:0] d);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    if (p == 0) begin
      bus.req0_r_wb = rwb; bus.req0_addr = a; bus.req0_data_w = d; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_r_wb = rwb; bus.req1_addr = a; bus.req1_data_w = d; bus.req1_valid = 1'b1;
    end
    for (int i = 0; i < 100; i++) begin
      #1;
      if ((p == 0) ? bus.req0_ready : bus.req1_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("send_ready", got, 1'b1);
    @(posedge clk); #1;
    if (p == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 300 && rsp_port.size() < n; i++) @(posedge clk);
    #1;
    chk("rsp_arrived", rsp_port.size() >= n, 1'b1);
  endtask

  task automatic wait_bridge(input int n);
    for (int i = 0; i < 300 && br_done < n; i++) @(posedge clk);
    #1;
    chk("bridge_done", br_done >= n, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int r, s, n0, n1, bd;

    bus.req0_valid = 1'b0; bus.req0_r_wb = 1'b0; bus.req0_addr = '0; bus.req0_data_w = '0;
    bus.req1_valid = 1'b0; bus.req1_r_wb = 1'b0; bus.req1_addr = '0; bus.req1_data_w = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_cin", bus.C_in_valid, 0);
    chk("rst_addr", bus.C_addr, 0);
    chk("rst_rsp_data", bus.rsp_data_r, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // both ports held valid from reset for 6 transactions
    br_lat = 3; br_data = 64'h0000_0000_0000_00AB;
    bus.req0_r_wb = 1'b1; bus.req0_addr = 8'h10;
    bus.req1_r_wb = 1'b1; bus.req1_addr = 8'h20;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 200 && rdy_port.size() < 6; i++) begin
      @(posedge clk); #1;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    chk("rr_grants", rdy_port.size(), 6);
    wait_rsp(6);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_grant%0d", i), rdy_port[i], i % 2);
      chk($sformatf("rr_rsp%0d", i), rsp_port[i], i % 2);
      if (rsp_port[i] == 0) n0++; else n1++;
    end
    chk("rr_cnt0", n0, 3);
    chk("rr_cnt1", n1, 3);
    chk("rr_next_after_rsp", rdy_cyc[1], rsp_cyc[0] + 1);
    chk("rr_spacing", rdy_cyc[1] - rdy_cyc[0], 6);

    // port0 read, L=10
    br_lat = 10; br_data = 64'hDEAD_BEEF_0000_0001;
    r = rdy_port.size(); s = rsp_port.size();
    send(0, 1'b1, 8'h05, 64'h0);
    wait_rsp(s + 1);
    chk("t1_port", rdy_port[r], 0);
    chk("t1_cin_cyc", cin_cyc, rdy_cyc[r] + 1);
    chk("t1_cin_rwb", cin_rwb, 1'b1);
    chk("t1_cin_addr", cin_addr, 8'h05);
    chk("t1_rsp_cyc", rsp_cyc[s], rdy_cyc[r] + 12);
    chk("t1_rsp_port", rsp_port[s], 0);
    chk("t1_rsp_data", rsp_data[s], 64'hDEAD_BEEF_0000_0001);
    chk("t1_rsp_err", rsp_errq[s], 1'b0);

    // port1 write, fields held through WAIT
    br_lat = 5; br_data = 64'hCAFE_0000_0000_0004;
    s = rsp_port.size();
    send(1, 1'b0, 8'hFF, 64'h1234);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_rwb", bus.C_r_wb, 1'b0);
      chk("t4_hold_addr", bus.C_addr, 8'hFF);
      chk("t4_hold_dw", bus.C_data_w, 64'h1234);
    end
    wait_rsp(s + 1);
    repeat (10) @(posedge clk);
    #1;
    chk("t4_rsp_count", rsp_port.size(), s + 1);
    chk("t4_rsp_port", rsp_port[s], 1);
    chk("t4_rsp_data", rsp_data[s], 64'hCAFE_0000_0000_0004);

    // timeout: bridge answers only after the watchdog fired
    br_lat = 25; br_data = 64'h5555_5555_5555_5555;
    r = rdy_port.size(); s = rsp_port.size(); bd = br_done;
    send(0, 1'b1, 8'h11, 64'h0);
    wait_rsp(s + 1);
    chk("t5_rsp_cyc", rsp_cyc[s], rdy_cyc[r] + 18);
    chk("t5_rsp_port", rsp_port[s], 0);
    chk("t5_rsp_err", rsp_errq[s], 1'b1);
    chk("t5_rsp_data", rsp_data[s], 64'h0);
    wait_bridge(bd + 1);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_late_busy", bus.busy, 0);
    chk("t5_late_norsp", rsp_port.size(), s + 1);
    chk("t5_late_data", bus.rsp_data_r, 64'h0);
    br_lat = 2; br_data = 64'h7777;
    r = rdy_port.size(); s = rsp_port.size();
    send(1, 1'b1, 8'h22, 64'h0);
    wait_rsp(s + 1);
    chk("t5_next_cyc", rsp_cyc[s], rdy_cyc[r] + 4);
    chk("t5_next_err", rsp_errq[s], 1'b0);
    chk("t5_next_data", rsp_data[s], 64'h7777);

    // reset during WAIT
    br_lat = 25;
    s = rsp_port.size(); bd = br_done;
    send(0, 1'b1, 8'h33, 64'h0);
    repeat (4) @(posedge clk);
    #3;
    chk("t6_pre_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", bus.busy, 0);
    chk("t6_rwb", bus.C_r_wb, 0);
    chk("t6_addr", bus.C_addr, 0);
    chk("t6_rsp_data", bus.rsp_data_r, 0);
    chk("t6_rsp_err", bus.rsp_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_bridge(bd + 1);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_norsp", rsp_port.size(), s);
    chk("t6_stray_busy", bus.busy, 0);
    br_lat = 2; br_data = 64'h0BAD_F00D;
    r = rdy_port.size();
    bus.req0_addr = 8'h44; bus.req1_addr = 8'h55;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 50 && rdy_port.size() <= r; i++) begin
      @(posedge clk); #1;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    chk("t6_tie_port", rdy_port[r], 0);
    wait_rsp(s + 1);
    chk("t6_rsp_port", rsp_port[s], 0);
    chk("t6_rsp_data", rsp_data[s], 64'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
